// File: rtl/prbs_checker.sv
// Locks onto a 4-bit PRBS (x^4+x+1 style, b[n]=b[n-3]^b[n-4]) and counts bit errors once locked.
// Latency: one clock from a sampled bit to locked/err_pulse/err_count. No backpressure; bit_valid gates sampling.
module prbs_checker #(
    parameter int LOCK_CNT    = 8,
    parameter int UNLOCK_ERRS = 4,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } st_t;

    localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_ERRS);

    st_t              cur, nxt;
    logic [3:0]       h, h_nxt;
    logic [3:0]       good_cnt, good_nxt;
    logic [3:0]       bad_cnt, bad_nxt;
    logic [1:0]       seed_cnt, seed_nxt;
    logic             pred, mism;
    logic             locked_nxt, pulse_nxt;
    logic [ERR_W-1:0] cnt_nxt;

    assign pred  = h[0] ^ h[1];
    assign mism  = (bit_in != pred);
    assign state = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= SEED;
            h         <= 4'd0;
            good_cnt  <= 4'd0;
            bad_cnt   <= 4'd0;
            seed_cnt  <= 2'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            cur       <= nxt;
            h         <= h_nxt;
            good_cnt  <= good_nxt;
            bad_cnt   <= bad_nxt;
            seed_cnt  <= seed_nxt;
            locked    <= locked_nxt;
            err_pulse <= pulse_nxt;
            err_count <= cnt_nxt;
        end
    end

    always_comb begin
        nxt      = cur;
        h_nxt    = h;
        good_nxt = good_cnt;
        bad_nxt  = bad_cnt;
        seed_nxt = seed_cnt;
        if (bit_valid) begin
            case (cur)
                SEED: begin
                    h_nxt    = {bit_in, h[3:1]};
                    seed_nxt = seed_cnt + 2'd1;
                    if (seed_cnt == 2'd3) begin
                        nxt      = HUNT;
                        seed_nxt = 2'd0;
                    end
                end
                HUNT: begin
                    h_nxt = {bit_in, h[3:1]};
                    // An all-zero history is the PRBS lock-up state, never evidence of sync.
                    if (!mism && h != 4'd0) begin
                        good_nxt = good_cnt + 4'd1;
                        if (good_cnt + 4'd1 == LOCK_C) begin
                            nxt      = LOCKED;
                            good_nxt = 4'd0;
                        end
                    end else begin
                        good_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    // Free-run on our own prediction so line errors never pollute the reference.
                    h_nxt = {pred, h[3:1]};
                    if (mism) begin
                        bad_nxt = bad_cnt + 4'd1;
                        if (bad_cnt + 4'd1 == UNLOCK_C) begin
                            nxt      = SEED;
                            bad_nxt  = 4'd0;
                            good_nxt = 4'd0;
                            seed_nxt = 2'd0;
                        end
                    end else begin
                        bad_nxt = 4'd0;
                    end
                end
                default: nxt = SEED;
            endcase
        end
    end

    always_comb begin
        locked_nxt = (nxt == LOCKED);
        pulse_nxt  = bit_valid && (cur == LOCKED) && mism;
        cnt_nxt    = err_count;
        if (clr_err)
            cnt_nxt = '0;
        else if (pulse_nxt && err_count != {ERR_W{1'b1}})
            cnt_nxt = err_count + ERR_W'(1);
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker with a queue-based reference model compared every cycle.
module tb_prbs_checker;

    localparam int LOCK_CNT    = 8;
    localparam int UNLOCK_ERRS = 4;
    localparam int ERR_W       = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             bit_valid, bit_in, clr_err;
    logic             locked, err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       state;

    prbs_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERRS(UNLOCK_ERRS), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .state     (state)
    );

    always #5 clk = ~clk;

    bit gen_seq [15] = '{1,0,0,1,1,0,1,0,1,1,1,1,0,0,0};
    int gi = 0;
    int nchk = 0;
    int npass = 0;
    bit run_cmp = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: keeps the last four reference bits as a plain list.
    int m_state, m_good, m_bad, m_nseed, m_cnt, ones;
    bit m_locked, m_pulse, pb;
    bit q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_good = 0; m_bad = 0; m_nseed = 0; m_cnt = 0;
            m_locked = 0; m_pulse = 0;
            q.delete();
        end else begin
            m_pulse = 0;
            if (bit_valid) begin
                pb = (q.size() >= 4) ? (q[q.size()-3] ^ q[q.size()-4]) : 1'b0;
                ones = 0;
                foreach (q[i]) ones += int'(q[i]);
                if (m_state == 0) begin
                    q.push_back(bit_in);
                    m_nseed++;
                    if (m_nseed == 4) begin m_state = 1; m_nseed = 0; end
                end else if (m_state == 1) begin
                    m_good = (bit_in == pb && ones != 0) ? m_good + 1 : 0;
                    q.push_back(bit_in);
                    if (m_good == LOCK_CNT) begin m_state = 2; m_good = 0; end
                end else begin
                    q.push_back(pb);
                    if (bit_in != pb) begin
                        m_pulse = 1;
                        if (m_cnt < (1 << ERR_W) - 1) m_cnt++;
                        m_bad++;
                        if (m_bad == UNLOCK_ERRS) begin
                            m_state = 0; m_bad = 0; m_nseed = 0; q.delete();
                        end
                    end else begin
                        m_bad = 0;
                    end
                end
                while (q.size() > 4) void'(q.pop_front());
            end
            if (clr_err) m_cnt = 0;
            m_locked = (m_state == 2);
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("cmp_state", int'(state), m_state);
            chk("cmp_locked", int'(locked), int'(m_locked));
            chk("cmp_err_pulse", int'(err_pulse), int'(m_pulse));
            chk("cmp_err_count", int'(err_count), m_cnt);
        end
    end

    task automatic send(input bit v, input bit b, input bit c);
        bit_valid = v; bit_in = b; clr_err = c;
        @(posedge clk); #1;
        bit_valid = 1'b0; clr_err = 1'b0;
    endtask

    task automatic send_gen(input bit inv, input bit clr = 1'b0);
        send(1'b1, gen_seq[gi] ^ inv, clr);
        gi = (gi + 1) % 15;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    int pulses;
    bit seen;

    initial begin
        rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clr_err = 1'b0;
        #12;
        chk("rst_state", int'(state), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_pulse", int'(err_pulse), 0);
        chk("rst_count", int'(err_count), 0);
        @(negedge clk) rst_n = 1'b1;
        run_cmp = 1'b1;
        @(posedge clk); #1;

        // Clean stream: HUNT after 4 bits, locked after 12.
        gi = 0;
        repeat (4) send_gen(1'b0);
        chk("seed_to_hunt", int'(state), 1);
        repeat (7) send_gen(1'b0);
        chk("unlocked_at_11", int'(locked), 0);
        send_gen(1'b0);
        chk("locked_at_12", int'(locked), 1);
        chk("clean_count", int'(err_count), 0);

        // Single inverted bit.
        send_gen(1'b1);
        chk("single_pulse", int'(err_pulse), 1);
        chk("single_count", int'(err_count), 1);
        chk("single_still_locked", int'(locked), 1);
        send_gen(1'b0);
        chk("pulse_one_cycle", int'(err_pulse), 0);
        pulses = 0;
        repeat (30) begin send_gen(1'b0); pulses += int'(err_pulse); end
        chk("no_spurious_pulses", pulses, 0);
        chk("count_held", int'(err_count), 1);

        // Burst of UNLOCK_ERRS errors drops lock; relock after 12 more bits.
        send_gen(1'b0, 1'b1);
        chk("clr_count", int'(err_count), 0);
        repeat (3) send_gen(1'b1);
        chk("locked_after_3_errs", int'(state), 2);
        send_gen(1'b1);
        chk("burst_count", int'(err_count), 4);
        chk("burst_to_seed", int'(state), 0);
        chk("burst_unlocked", int'(locked), 0);
        repeat (11) send_gen(1'b0);
        chk("relock_not_yet", int'(locked), 0);
        send_gen(1'b0);
        chk("relocked", int'(locked), 1);
        chk("relock_count_kept", int'(err_count), 4);

        // Clear coinciding with an error: clear wins, pulse still fires.
        send_gen(1'b1, 1'b1);
        chk("clr_wins_count", int'(err_count), 0);
        chk("clr_pulse", int'(err_pulse), 1);

        // Asynchronous reset mid-cycle while locked.
        #2 rst_n = 1'b0;
        #1;
        chk("async_locked", int'(locked), 0);
        chk("async_count", int'(err_count), 0);
        chk("async_state", int'(state), 0);
        chk("async_pulse", int'(err_pulse), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Constant streams never lock.
        seen = 1'b0;
        repeat (40) begin send(1'b1, 1'b0, 1'b0); seen |= locked; end
        chk("zeros_never_lock", int'(seen), 0);
        chk("zeros_count", int'(err_count), 0);
        do_reset();
        seen = 1'b0;
        repeat (40) begin send(1'b1, 1'b1, 1'b0); seen |= locked; end
        chk("ones_never_lock", int'(seen), 0);
        chk("ones_hunting", int'(state), 1);

        // bit_valid every other cycle, garbage on invalid cycles.
        do_reset();
        gi = 0;
        for (int k = 1; k <= 12; k++) begin
            send_gen(1'b0);
            if (k == 11) chk("sparse_not_yet", int'(locked), 0);
            send(1'b0, ~gen_seq[gi], 1'b0);
        end
        chk("sparse_locked", int'(locked), 1);
        chk("sparse_count", int'(err_count), 0);

        repeat (2) @(posedge clk);
        #1;
        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
